// File: rtl/mult_sched_defs_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
package mult_sched_defs;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int ptr_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first set request at or after ptr wins, purely combinational.
// Zero latency; no backpressure of its own, the caller decides when a grant is consumed.
module rr_arbiter
    import mult_sched_defs::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = ptr_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            any
);

    logic [NREQ-1:0] rot_req;
    logic [NREQ-1:0] rot_gnt;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % NREQ);
    endfunction

    // Rotate so ptr lands at bit 0, pick the lowest set bit, then rotate back.
    always_comb begin
        rot_req = '0;
        rot_gnt = '0;
        gnt     = '0;
        gnt_idx = '0;
        for (int j = 0; j < NREQ; j++) begin
            rot_req[j] = req[wrap(j + int'(ptr))];
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot_req[j]) begin
                rot_gnt = NREQ'(1) << j;
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            gnt[wrap(j + int'(ptr))] = rot_gnt[j];
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mult_scheduler.sv
// Shares one multiplier among NREQ requesters, round-robin; accept->start 1 cycle, done->resp 1 cycle.
// Requesters are held off (req_ready low) while a job is in flight; a watchdog aborts a hung datapath.
module mult_scheduler
    import mult_sched_defs::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         resp_valid,
    output logic [2*WIDTH-1:0]      resp_data,
    output logic                    resp_err,
    output logic                    busy,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    output logic                    mul_rst,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_result
);

    localparam int PW   = ptr_w(NREQ);
    localparam int WD_W = $clog2(TIMEOUT);

    state_t             state, state_nxt;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      gnt_idx;
    logic [WD_W-1:0]    wd;
    logic [2*WIDTH-1:0] res_q;
    logic               err_q;
    logic [NREQ-1:0]    arb_gnt;
    logic [PW-1:0]      arb_idx;
    logic               arb_any;
    logic               wd_expired;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign wd_expired = (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        mul_start  = 1'b0;
        resp_valid = '0;
        mul_rst    = 1'b0;
        case (state)
            IDLE: begin
                // Grant is suppressed during reset so nothing looks accepted.
                if (arb_any && !rst) begin
                    req_ready = arb_gnt;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (mul_done || wd_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = NREQ'(1) << gnt_idx;
                mul_rst    = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            gnt_idx <= '0;
            wd      <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        mul_a   <= req_a[int'(arb_idx)*WIDTH +: WIDTH];
                        mul_b   <= req_b[int'(arb_idx)*WIDTH +: WIDTH];
                        gnt_idx <= arb_idx;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    // A done in the final watchdog cycle still counts as success.
                    if (mul_done) begin
                        res_q <= mul_result;
                        err_q <= 1'b0;
                    end else if (wd_expired) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign resp_data = res_q;
    assign resp_err  = err_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed + randomized bench for mult_scheduler with a cycle-level multiplier model
// and a round-robin / timing reference model kept at the transaction level.
module tb_mult_scheduler;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_ready, resp_valid;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [2*WIDTH-1:0]    resp_data, mul_result;
    logic                  resp_err, busy, mul_start, mul_rst, mul_done;
    logic [WIDTH-1:0]      mul_a, mul_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_at = -1;
    logic [2*WIDTH-1:0] done_val;
    logic [NREQ-1:0]    pend;
    logic [WIDTH-1:0]   oa [NREQ];
    logic [WIDTH-1:0]   ob [NREQ];
    int ptr_m = 0;
    bit keep = 1'b0;

    mult_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rst    (mul_rst),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One bench cycle: drive inputs at the falling edge, sample outputs 1ns later.
    task automatic step();
        @(negedge clk);
        cyc++;
        req_valid = pend;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = oa[i];
            req_b[i*WIDTH +: WIDTH] = ob[i];
        end
        mul_done   = (cyc == done_at);
        mul_result = mul_done ? done_val : 16'($urandom);
        #1;
    endtask

    function automatic int model_winner();
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic accept(output int w, output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
        int n = 0;
        w = model_winner();
        step();
        while (req_ready == '0 && n < 50) begin
            step();
            n++;
        end
        chk("req_ready", 32'(req_ready), 32'(1) << w);
        a = oa[w];
        b = ob[w];
        if (keep) begin
            oa[w] = WIDTH'($urandom);
            ob[w] = WIDTH'($urandom);
        end else begin
            pend[w] = 1'b0;
        end
    endtask

    // Multiplier answers lat cycles after start; lat > TIMEOUT means it never answers in time.
    task automatic run_job(input int lat);
        int w, t0, n, starts, rel;
        logic [WIDTH-1:0] a, b;
        logic err;
        logic [2*WIDTH-1:0] prod;
        accept(w, a, b);
        t0   = cyc;
        err  = (lat > TIMEOUT);
        prod = err ? '0 : (2*WIDTH)'(a) * (2*WIDTH)'(b);
        rel  = 2 + (err ? TIMEOUT : lat);
        step();
        chk("mul_start", 32'(mul_start), 1);
        done_val = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        done_at  = cyc + lat;
        starts = 0;
        n = 0;
        do begin
            step();
            starts += int'(mul_start);
            n++;
        end while (resp_valid == '0 && n < TIMEOUT + lat + 10);
        chk("resp_cycle", 32'(cyc - t0), 32'(rel));
        chk("resp_valid", 32'(resp_valid), 32'(1) << w);
        chk("resp_data", 32'(resp_data), 32'(prod));
        chk("resp_err", 32'(resp_err), 32'(err));
        chk("mul_rst", 32'(mul_rst), 32'(err));
        chk("mul_a_hold", 32'(mul_a), 32'(a));
        chk("mul_b_hold", 32'(mul_b), 32'(b));
        chk("extra_start", 32'(starts), 0);
        ptr_m   = (w + 1) % NREQ;
        done_at = -1;
    endtask

    initial begin
        int w, bad;
        logic [WIDTH-1:0] a, b;
        logic [NREQ-1:0] add;

        rst = 1'b1;
        pend = '0;
        mul_done = 1'b0;
        mul_result = '0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            oa[i] = '0;
            ob[i] = '0;
        end

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_mul_rst", 32'(mul_rst), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        chk("rst_resp_data", 32'(resp_data), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        rst = 1'b0;
        step();
        chk("idle_req_ready", 32'(req_ready), 0);

        // Single request: 12 * 11
        oa[0] = 8'd12;
        ob[0] = 8'd11;
        pend = 4'b0001;
        run_job(10);

        // Fairness with all four held high, then drain
        for (int i = 0; i < NREQ; i++) begin
            oa[i] = WIDTH'($urandom);
            ob[i] = WIDTH'($urandom);
        end
        pend = 4'b1111;
        keep = 1'b1;
        for (int k = 0; k < 5; k++) run_job(int'($urandom_range(1, 12)));
        keep = 1'b0;
        for (int k = 0; k < 4; k++) run_job(int'($urandom_range(1, 12)));

        // Pointer skip: serve 1, then 0011 must go to 0 first
        pend = 4'b0010;
        run_job(3);
        pend = 4'b0011;
        run_job(4);
        run_job(2);

        // Timeout, then a stale done that must be ignored
        oa[2] = 8'd200;
        ob[2] = 8'd201;
        pend = 4'b0100;
        run_job(40);
        done_val = 16'hBEEF;
        done_at = cyc + 3;
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (resp_valid != '0 || busy || mul_rst) bad++;
        end
        chk("stale_done_ignored", 32'(bad), 0);
        done_at = -1;

        // Watchdog boundaries: done in last cycle, one late, minimum latency
        oa[0] = 8'd255;
        ob[0] = 8'd255;
        pend = 4'b0001;
        run_job(TIMEOUT);
        pend = 4'b0001;
        run_job(TIMEOUT + 1);
        pend = 4'b0001;
        run_job(1);

        // Randomized traffic
        for (int k = 0; k < 20; k++) begin
            add = NREQ'($urandom) & ~pend;
            if (pend == '0 && add == '0) add = NREQ'(1) << $urandom_range(0, NREQ - 1);
            for (int i = 0; i < NREQ; i++) begin
                if (add[i]) begin
                    oa[i] = WIDTH'($urandom);
                    ob[i] = WIDTH'($urandom);
                end
            end
            pend = pend | add;
            run_job(int'($urandom_range(1, TIMEOUT + 3)));
        end
        while (pend != '0) run_job(int'($urandom_range(1, 8)));

        // Reset in the middle of WAIT
        oa[3] = 8'd7;
        ob[3] = 8'd9;
        pend = 4'b1000;
        accept(w, a, b);
        step();
        done_val = 16'd63;
        done_at = cyc + 50;
        step();
        step();
        chk("midwait_busy", 32'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_resp_valid", 32'(resp_valid), 0);
        chk("mrst_mul_a", 32'(mul_a), 0);
        chk("mrst_mul_b", 32'(mul_b), 0);
        chk("mrst_resp_data", 32'(resp_data), 0);
        chk("mrst_resp_err", 32'(resp_err), 0);
        chk("mrst_mul_start", 32'(mul_start), 0);
        chk("mrst_mul_rst", 32'(mul_rst), 0);
        ptr_m = 0;
        bad = 0;
        for (int k = 0; k < 52; k++) begin
            step();
            if (resp_valid != '0 || busy) bad++;
        end
        chk("mrst_no_resp", 32'(bad), 0);
        done_at = -1;
        for (int i = 0; i < NREQ; i++) begin
            oa[i] = WIDTH'($urandom);
            ob[i] = WIDTH'($urandom);
        end
        pend = 4'b1111;
        run_job(5);
        while (pend != '0) run_job(int'($urandom_range(1, 6)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
